flag_unit: RTL and testbench
============================

# flag_unit

Flag-producing end of the branch path: captures the Z, V, N condition flags from the EX-stage ALU result, holds the architectural flag register, and supplies a 3-bit flag vector {Z,V,N} to the branch-resolution logic in ID. Also detects the EX→ID flag hazard, either resolving it by forwarding or by requesting a one-cycle ID stall. Sits between the ALU output and the next-PC/branch condition evaluator.

## Interface

- No parameters; all widths fixed (16-bit datapath, 4-bit opcode, 3-bit flags).

- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- ex_valid  input  1  EX holds a real instruction (0 = bubble)
- ex_opcode  input  4  opcode of EX instruction
- ex_result  input  16  ALU result of EX instruction (post-saturation)
- ex_ovfl  input  1  signed overflow from EX adder
- stall  input  1  pipeline freeze; EX instruction neither commits nor advances
- flush  input  1  squash EX instruction; no flag commit
- id_branch  input  1  ID holds a conditional branch (B or BR) that reads flags
- flags_q  output  3  architectural flags {Z,V,N}: [2]=Z, [1]=V, [0]=N
- id_flags  output  3  flags delivered to branch evaluation, same encoding
- flag_stall  output  1  request to hold ID/IF one cycle
- halted  output  1  HLT has committed; flags frozen
- upd_cnt  output  8  saturating count of committed flag updates

## Operation

- Flag-setting classes (by ex_opcode):
  - ADD 0000, SUB 0001: write Z, V, N.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: write Z only; V, N keep prior value.
  - All other opcodes: no flag write. HLT 1111 is special (below).
- Next-flag values: Z = (ex_result == 16'h0000); N = ex_result[15]; V = ex_ovfl.
- commit = ex_valid & ~stall & ~flush & (state == RUN) & setter(ex_opcode).
- State machine, two states:
  - RUN (reset state): flags update on commit.
  - HALT: entered the cycle after ex_valid & ~stall & ~flush & ex_opcode == 1111 while in RUN. No flag writes, upd_cnt frozen, flag_stall = 0, halted = 1. Leaves only on rst.
- upd_cnt increments by 1 on each commit; saturates at 8'hFF (no wrap).
- hazard = id_branch & ex_valid & ~flush & setter(ex_opcode) & (state == RUN).
- stall and flush together: no commit, no HLT transition; flush has no further effect here.

## Timing

- Reset values (cycle after rst sampled high): flags_q = 3'b000, state = RUN, halted = 0, upd_cnt = 8'h00; flag_stall = 0 and id_flags = 3'b000 while no EX instruction is valid.
- flags_q updates at the rising edge ending the EX cycle of the committing instruction; visible in flags_q the following cycle (1-cycle latency).
- id_flags, flag_stall are combinational from current inputs and registered state; flags_q, halted, upd_cnt are registered only.
- Partial update merge: for Z-only ops, forwarded/committed vector is {Z_new, V_q, N_q}.
- Back-to-back setters: each commits on its own edge; last writer wins per bit.
- rst asserted mid-operation overrides any pending commit or HLT in the same cycle.

## Configuration

- FLAG_FWD_EN defined: id_flags = merged next-flag vector when hazard is true and stall = 0, else flags_q; flag_stall tied 0. Branch in ID resolves in the same cycle the producer is in EX.
- FLAG_FWD_EN undefined: id_flags = flags_q always; flag_stall = hazard. ID holds one cycle; EX then contains a bubble, hazard clears, and the branch reads the newly committed flags_q.

## Test plan

- Reset: assert rst 2 cycles with ex_valid=1, ADD, result 0 → flags_q=000, upd_cnt=0, halted=0 after release.
- ADD result 16'h8000, ovfl=1, commit → next cycle flags_q=011; then SUB result 0, ovfl=0 → flags_q=100; upd_cnt=2.
- Flags 011, XOR result 0 → flags_q=111 (V,N kept); SLL result 16'h0001 → 011.
- Hazard: ADD result 0 in EX with id_branch=1 → FLAG_FWD_EN: flag_stall=0, id_flags=100 same cycle; without: flag_stall=1 for exactly one cycle, id_flags=100 the next cycle.
- ADD with flush=1, then ADD with stall=1 → flags_q and upd_cnt unchanged; flag_stall=0 under flush.
- HLT committed, then ADD result 0 → halted=1, flags_q unchanged, flag_stall=0 with id_branch=1; rst returns to RUN with flags_q=000.

Source files
------------

// File: rtl/flag_unit_if.sv
// Condition-flag bus between the EX/ID pipeline stages and flag_unit.
// The master modport drives the EX/ID side; the slave modport is flag_unit itself.
interface flag_unit_if;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic        ex_ovfl;
    logic        stall;
    logic        flush;
    logic        id_branch;
    logic [2:0]  flags_q;
    logic [2:0]  id_flags;
    logic        flag_stall;
    logic        halted;
    logic [7:0]  upd_cnt;

    modport master (
        output ex_valid, ex_opcode, ex_result, ex_ovfl, stall, flush, id_branch,
        input  flags_q, id_flags, flag_stall, halted, upd_cnt
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_result, ex_ovfl, stall, flush, id_branch,
        output flags_q, id_flags, flag_stall, halted, upd_cnt
    );
endinterface

// File: rtl/flag_unit.sv
// Purpose: architectural {Z,V,N} flag register, EX->ID flag hazard detect/forward; FLAG_FWD_EN selects forwarding.
// Latency: flags_q one cycle after commit; id_flags/flag_stall combinational (forwarded same cycle when enabled).
// Backpressure: stall/flush suppress commit; without forwarding a flag hazard raises flag_stall for one cycle.
module flag_unit (
    input  logic         clk,
    input  logic         rst,
    flag_unit_if.slave   fu
);
    typedef enum logic {RUN, HALT} state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t      state_q, state_d;
    logic [2:0]  flags_q, flags_d;
    logic [7:0]  upd_cnt_q, upd_cnt_d;

    logic        sets_all;
    logic        sets_z;
    logic        in_run;
    logic        issue;
    logic        commit;
    logic        hazard;
    logic [2:0]  merged;

    always_comb begin
        sets_all = (fu.ex_opcode == OP_ADD) || (fu.ex_opcode == OP_SUB);
        sets_z   = sets_all || (fu.ex_opcode == OP_XOR) || (fu.ex_opcode == OP_SLL)
                   || (fu.ex_opcode == OP_SRA) || (fu.ex_opcode == OP_ROR);
        in_run   = (state_q == RUN);
        issue    = fu.ex_valid && !fu.stall && !fu.flush;
        commit   = issue && in_run && sets_z;
        hazard   = fu.id_branch && fu.ex_valid && !fu.flush && sets_z && in_run;

        // Z-only ops keep the held V and N bits.
        merged   = sets_all ? {(fu.ex_result == 16'h0000), fu.ex_ovfl, fu.ex_result[15]}
                            : {(fu.ex_result == 16'h0000), flags_q[1:0]};

        flags_d   = commit ? merged : flags_q;
        upd_cnt_d = (commit && (upd_cnt_q != 8'hFF)) ? upd_cnt_q + 8'd1 : upd_cnt_q;
        state_d   = (in_run && issue && (fu.ex_opcode == OP_HLT)) ? HALT : state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            flags_q   <= 3'b000;
            upd_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            upd_cnt_q <= upd_cnt_d;
        end
    end

    assign fu.flags_q = flags_q;
    assign fu.upd_cnt = upd_cnt_q;
    assign fu.halted  = (state_q == HALT);

`ifdef FLAG_FWD_EN
    assign fu.id_flags   = (hazard && !fu.stall) ? merged : flags_q;
    assign fu.flag_stall = 1'b0;
`else
    assign fu.id_flags   = flags_q;
    assign fu.flag_stall = hazard;
`endif
endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: fixed vector table, hazard/saturation sequences, then random traffic vs a flag model.
module tb_flag_unit;
    logic clk;
    logic rst;
    flag_unit_if fu ();

    flag_unit dut (.clk(clk), .rst(rst), .fu(fu));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: separate flag bits, integer counter, halt bit.
    bit m_init = 0;
    bit m_z, m_v, m_n, m_halt;
    int m_cnt;

    function automatic bit writes_z(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
    endfunction

    function automatic bit writes_vn(input logic [3:0] op);
        return op inside {4'd0, 4'd1};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] op,
                         input logic [15:0] res, input logic ov, input logic st,
                         input logic fl, input logic br);
        bit hz;
        logic [2:0] exp_id;
        logic [2:0] newf;
        @(negedge clk);
        rst = r; fu.ex_valid = v; fu.ex_opcode = op; fu.ex_result = res;
        fu.ex_ovfl = ov; fu.stall = st; fu.flush = fl; fu.id_branch = br;
        #1;
        newf = {(res == 16'h0), writes_vn(op) ? ov : m_v, writes_vn(op) ? res[15] : m_n};
        if (m_init) begin
            hz = br && v && !fl && writes_z(op) && !m_halt;
            chk("flags_q", int'(fu.flags_q), int'({m_z, m_v, m_n}));
            chk("upd_cnt", int'(fu.upd_cnt), m_cnt);
            chk("halted", int'(fu.halted), int'(m_halt));
`ifdef FLAG_FWD_EN
            exp_id = (hz && !st) ? newf : {m_z, m_v, m_n};
            chk("flag_stall", int'(fu.flag_stall), 0);
`else
            exp_id = {m_z, m_v, m_n};
            chk("flag_stall", int'(fu.flag_stall), int'(hz));
`endif
            chk("id_flags", int'(fu.id_flags), int'(exp_id));
        end
        @(posedge clk);
        if (r) begin
            m_init = 1; m_z = 0; m_v = 0; m_n = 0; m_halt = 0; m_cnt = 0;
        end else if (!m_halt && v && !st && !fl) begin
            if (writes_z(op)) begin
                {m_z, m_v, m_n} = newf;
                if (m_cnt < 255) m_cnt++;
            end
            if (op == 4'hF) m_halt = 1;
        end
    endtask

    typedef struct {
        logic        r, v;
        logic [3:0]  op;
        logic [15:0] res;
        logic        ov, st, fl, br;
        logic [2:0]  exp_flags;
        logic [7:0]  exp_cnt;
        logic        exp_halt;
    } vec_t;

    vec_t vecs[15];

    initial begin
        rst = 1; fu.ex_valid = 0; fu.ex_opcode = 0; fu.ex_result = 0;
        fu.ex_ovfl = 0; fu.stall = 0; fu.flush = 0; fu.id_branch = 0;

        //          r  v  op     res        ov st fl br  flags   cnt    halt
        vecs[0]  = '{1, 1, 4'h0, 16'h0000, 0, 0, 0, 0, 3'b000, 8'd0, 0};
        vecs[1]  = '{1, 1, 4'h0, 16'h0000, 0, 0, 0, 0, 3'b000, 8'd0, 0};
        vecs[2]  = '{0, 1, 4'h0, 16'h8000, 1, 0, 0, 0, 3'b011, 8'd1, 0};
        vecs[3]  = '{0, 1, 4'h1, 16'h0000, 0, 0, 0, 0, 3'b100, 8'd2, 0};
        vecs[4]  = '{0, 1, 4'h0, 16'h8000, 1, 0, 0, 0, 3'b011, 8'd3, 0};
        vecs[5]  = '{0, 1, 4'h2, 16'h0000, 0, 0, 0, 0, 3'b111, 8'd4, 0};
        vecs[6]  = '{0, 1, 4'h4, 16'h0001, 0, 0, 0, 0, 3'b011, 8'd5, 0};
        vecs[7]  = '{0, 1, 4'h0, 16'h0000, 0, 0, 1, 1, 3'b011, 8'd5, 0};
        vecs[8]  = '{0, 1, 4'h0, 16'h0000, 0, 1, 0, 0, 3'b011, 8'd5, 0};
        vecs[9]  = '{0, 1, 4'h3, 16'h0000, 0, 0, 0, 0, 3'b011, 8'd5, 0};
        vecs[10] = '{0, 1, 4'hF, 16'h0000, 0, 1, 1, 0, 3'b011, 8'd5, 0};
        vecs[11] = '{0, 0, 4'hF, 16'h0000, 0, 0, 0, 0, 3'b011, 8'd5, 0};
        vecs[12] = '{0, 1, 4'hF, 16'h0000, 0, 0, 0, 0, 3'b011, 8'd5, 1};
        vecs[13] = '{0, 1, 4'h0, 16'h0000, 0, 0, 0, 1, 3'b011, 8'd5, 1};
        vecs[14] = '{1, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'b000, 8'd0, 0};

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].r, vecs[i].v, vecs[i].op, vecs[i].res, vecs[i].ov,
                  vecs[i].st, vecs[i].fl, vecs[i].br);
            #1;
            chk($sformatf("vec%0d flags_q", i), int'(fu.flags_q), int'(vecs[i].exp_flags));
            chk($sformatf("vec%0d upd_cnt", i), int'(fu.upd_cnt), int'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d halted", i), int'(fu.halted), int'(vecs[i].exp_halt));
        end

        // Flag hazard: ADD result 0 in EX with a branch in ID, then a bubble.
        @(negedge clk);
        rst = 0; fu.ex_valid = 1; fu.ex_opcode = 4'h0; fu.ex_result = 16'h0;
        fu.ex_ovfl = 0; fu.stall = 0; fu.flush = 0; fu.id_branch = 1;
        #1;
`ifdef FLAG_FWD_EN
        chk("haz flag_stall", int'(fu.flag_stall), 0);
        chk("haz id_flags", int'(fu.id_flags), 3'b100);
`else
        chk("haz flag_stall", int'(fu.flag_stall), 1);
        chk("haz id_flags", int'(fu.id_flags), 3'b000);
`endif
        @(posedge clk);
        m_z = 1; m_v = 0; m_n = 0; m_cnt++;
        @(negedge clk);
        fu.ex_valid = 0;
        #1;
        chk("haz2 flag_stall", int'(fu.flag_stall), 0);
        chk("haz2 id_flags", int'(fu.id_flags), 3'b100);

        // Counter saturation.
        for (int i = 0; i < 300; i++)
            drive(0, 1, 4'h1, 16'h0001, 0, 0, 0, 0);
        #1;
        chk("sat upd_cnt", int'(fu.upd_cnt), 255);
        chk("sat flags_q", int'(fu.flags_q), 3'b000);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [3:0]  op;
            logic [15:0] res;
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && ($urandom % 4) != 0) op = 4'h0;
            case ($urandom % 3)
                0: res = 16'h0000;
                1: res = 16'h8000 | 16'($urandom);
                default: res = 16'($urandom);
            endcase
            drive(($urandom % 40) == 0, ($urandom % 5) != 0, op, res, 1'($urandom),
                  ($urandom % 6) == 0, ($urandom % 6) == 0, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
